a19760319: RTL and testbench



---
 rtl/a19760319_pkg.sv | 23 ++
 rtl/a19760319_bcd_to_seg7.sv | 13 +
 rtl/a19760319.sv | 59 +++++
 tb/tb_a19760319.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/a19760319_pkg.sv
// Shared types and constant tables for the 1-9-7-6-0-3-1-9 digit ROM and its display path.
package a19760319_pkg;

   localparam int unsigned IDX_W = 3;
   localparam int unsigned BCD_W = 4;
   localparam int unsigned SEG_W = 7;

   typedef logic [BCD_W-1:0] bcd_t;
   typedef logic [IDX_W-1:0] idx_t;

   localparam bcd_t DIGITS [8] = '{
      4'd1, 4'd9, 4'd7, 4'd6, 4'd0, 4'd3, 4'd1, 4'd9
   };

   // Active-low {g,f,e,d,c,b,a}; codes 10..15 blank.
   localparam logic [SEG_W-1:0] SEG_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/a19760319_bcd_to_seg7.sv
// Table-driven BCD to active-low seven-segment decoder.
module bcd_to_seg7
   import a19760319_pkg::*;
(
   input  bcd_t             bcd_i,
   output logic [SEG_W-1:0] seg_n_o
);

   always_comb begin
      seg_n_o = SEG_LUT[bcd_i];
   end

endmodule

// File: rtl/a19760319.sv
// Digit ROM with a combinational lookup and a registered, optionally scanned, seven-segment display path.
module a19760319
   import a19760319_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] in,
   output logic [BCD_W-1:0] out,
   input  logic             scan_en,
   output logic [BCD_W-1:0] out_q,
   output logic [IDX_W-1:0] idx_q,
   output logic             valid_q,
   output logic [SEG_W-1:0] seg_n
);

   idx_t             ptr_q, ptr_d;
   idx_t             src_idx;
   bcd_t             src_dig;
   logic [SEG_W-1:0] seg_d;

   // Lookup is independent of clock and reset.
   always_comb begin
      out = DIGITS[in];
   end

   // Scanning uses the held pointer first, then advances it.
   always_comb begin
      src_idx = in;
      ptr_d   = ptr_q;
      if (scan_en) begin
         src_idx = ptr_q;
         ptr_d   = ptr_q + IDX_W'(1);
      end
      src_dig = DIGITS[src_idx];
   end

   bcd_to_seg7 u_seg (
      .bcd_i   (src_dig),
      .seg_n_o (seg_d)
   );

   // Segments are decoded ahead of the register so they land with out_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         seg_n   <= SEG_BLANK;
      end else begin
         ptr_q   <= ptr_d;
         idx_q   <= src_idx;
         out_q   <= src_dig;
         valid_q <= 1'b1;
         seg_n   <= seg_d;
      end
   end

endmodule

// File: tb/tb_a19760319.sv
// Scoreboard bench for a19760319: reference model built from the digit string and lit-segment lists.
module tb_a19760319;

   logic       clk;
   logic       rst;
   logic [2:0] in;
   logic [3:0] out;
   logic       scan_en;
   logic [3:0] out_q;
   logic [2:0] idx_q;
   logic       valid_q;
   logic [6:0] seg_n;

   a19760319 dut (
      .clk     (clk),
      .rst     (rst),
      .in      (in),
      .out     (out),
      .scan_en (scan_en),
      .out_q   (out_q),
      .idx_q   (idx_q),
      .valid_q (valid_q),
      .seg_n   (seg_n)
   );

   typedef struct packed {
      logic [2:0] idx;
      logic [3:0] dig;
      logic [6:0] seg;
   } exp_t;

   exp_t       sb_q[$];
   int         vectors = 0;
   int         miscompares = 0;
   logic [2:0] model_ptr = '0;
   bit         release_pending = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] ref_digit(input logic [2:0] idx);
      string s;
      s = "19760319";
      return 4'(s[int'(idx)] - 8'd48);
   endfunction

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      string lit;
      logic [6:0] r;
      case (d)
         4'd0: lit = "abcdef";
         4'd1: lit = "bc";
         4'd2: lit = "abdeg";
         4'd3: lit = "abcdg";
         4'd4: lit = "bcfg";
         4'd5: lit = "acdfg";
         4'd6: lit = "acdefg";
         4'd7: lit = "abc";
         4'd8: lit = "abcdefg";
         4'd9: lit = "abcdfg";
         default: lit = "";
      endcase
      r = 7'h7F;
      for (int k = 0; k < lit.len(); k++) r[int'(lit[k]) - 97] = 1'b0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; expectation is queued for the monitor.
   task automatic cycle(input bit se, input logic [2:0] iv);
      logic [2:0] src;
      exp_t e;
      @(negedge clk);
      if (release_pending) begin
         rst = 1'b1;
         release_pending = 0;
      end
      scan_en = se;
      in      = iv;
      src     = se ? model_ptr : iv;
      if (se) model_ptr = model_ptr + 3'd1;
      e.idx = src;
      e.dig = ref_digit(src);
      e.seg = ref_seg(e.dig);
      sb_q.push_back(e);
      #1;
      chk("comb_out", 8'(out), 8'(ref_digit(iv)));
   endtask

   // Asynchronous reset asserted mid-cycle; released at the next stimulus cycle.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_out_q", 8'(out_q), 8'h00);
      chk("rst_idx_q", 8'(idx_q), 8'h00);
      chk("rst_valid_q", 8'(valid_q), 8'h00);
      chk("rst_seg_n", 8'(seg_n), 8'h7F);
      sb_q.delete();
      model_ptr = '0;
      release_pending = 1;
   endtask

   // Monitor: compares every loaded digit against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            if (valid_q) begin
               if (sb_q.size() == 0) begin
                  chk("orphan_output", 8'(valid_q), 8'h00);
               end else begin
                  e = sb_q.pop_front();
                  chk("idx_q", 8'(idx_q), 8'(e.idx));
                  chk("out_q", 8'(out_q), 8'(e.dig));
                  chk("seg_n", 8'(seg_n), 8'(e.seg));
               end
            end else if (sb_q.size() != 0) begin
               chk("valid_q", 8'(valid_q), 8'h01);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b0;
      scan_en = 1'b0;
      in      = '0;
      #2;
      for (int i = 0; i < 8; i++) begin
         in = 3'(i);
         #1;
         chk("out_in_reset", 8'(out), 8'(ref_digit(3'(i))));
      end
      chk("init_out_q", 8'(out_q), 8'h00);
      chk("init_idx_q", 8'(idx_q), 8'h00);
      chk("init_valid_q", 8'(valid_q), 8'h00);
      chk("init_seg_n", 8'(seg_n), 8'h7F);
      release_pending = 1;

      cycle(0, 3'd3);
      for (int i = 0; i < 8; i++) cycle(0, 3'(i));

      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 3'($urandom_range(0, 7)));

      do_reset();
      for (int i = 0; i < 6; i++) cycle(1, 3'($urandom_range(0, 7)));
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1, 3'($urandom_range(0, 7)));
      cycle(0, 3'd2);
      cycle(0, 3'd6);
      for (int i = 0; i < 4; i++) cycle(1, 3'($urandom_range(0, 7)));

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         cycle(bit'($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)));
      end

      @(posedge clk);
      #2;
      chk("scoreboard_drained", 8'(sb_q.size()), 8'h00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
